// File: rtl/s2_port_arbiter.sv
// Round-robin arbiter sharing the s2 memory port between NUM_REQ requesters.
// Optional macro S2_ARB_WRITE_ACK_EN: accepted writes also return a response strobe.
module s2_port_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    localparam int BE_W        = DATA_W / 8
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*BE_W-1:0]   req_be,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         s2_address,
    output logic                      s2_chipselect,
    output logic                      s2_clken,
    output logic                      s2_write,
    output logic [DATA_W-1:0]         s2_writedata,
    output logic [BE_W-1:0]           s2_byteenable,
    input  logic [DATA_W-1:0]         s2_readdata
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int L     = READ_LATENCY;

    logic [IDX_W-1:0]   last_grant;
    logic               run;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic [NUM_REQ-1:0] grant_oh;
    logic               win_write;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;
    logic [BE_W-1:0]    win_be;

    logic [L:0]         tag_vld;
    logic [L:0]         tag_rd;
    logic [NUM_REQ-1:0] tag_oh [L+1];
    logic               rsp_fire;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        return IDX_W'(sum % NUM_REQ);
    endfunction

    // Grants are held off until the first edge after reset so req_ready reads 0 in reset.
    always_comb begin
        cand      = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = rr_idx(last_grant, k);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (!run) begin
            grant_any = 1'b0;
        end
        grant_oh = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    assign req_ready = grant_oh;

    always_comb begin
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        win_be    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                win_write = req_write[i];
                win_addr  = req_addr[i*ADDR_W +: ADDR_W];
                win_wdata = req_wdata[i*DATA_W +: DATA_W];
                win_be    = req_be[i*BE_W +: BE_W];
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            run           <= 1'b0;
            last_grant    <= IDX_W'(NUM_REQ - 1);
            s2_chipselect <= 1'b0;
            s2_write      <= 1'b0;
            s2_address    <= '0;
            s2_writedata  <= '0;
            s2_byteenable <= '0;
        end else begin
            run           <= 1'b1;
            s2_chipselect <= grant_any;
            s2_write      <= grant_any & win_write;
            if (grant_any) begin
                last_grant    <= grant_idx;
                s2_address    <= win_addr;
                s2_writedata  <= win_wdata;
                s2_byteenable <= win_be;
            end
        end
    end

    assign s2_clken = run;

    // Stage j holds the access issued j+1 cycles ago; stage L lines up with s2_readdata.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tag_vld <= '0;
            tag_rd  <= '0;
            for (int j = 0; j <= L; j++) begin
                tag_oh[j] <= '0;
            end
        end else begin
            tag_vld <= {tag_vld[L-1:0], grant_any};
            tag_rd  <= {tag_rd[L-1:0], grant_any & ~win_write};
            tag_oh[0] <= grant_oh;
            for (int j = 1; j <= L; j++) begin
                tag_oh[j] <= tag_oh[j-1];
            end
        end
    end

`ifdef S2_ARB_WRITE_ACK_EN
    assign rsp_fire  = tag_vld[L];
    assign rsp_rdata = (tag_vld[L] && !tag_rd[L]) ? '0 : s2_readdata;
`else
    assign rsp_fire  = tag_vld[L] & tag_rd[L];
    assign rsp_rdata = s2_readdata;
`endif

    assign rsp_valid = rsp_fire ? tag_oh[L] : '0;

endmodule
